// File: rtl/sad_min_select.sv
// rtl/sad_min_select.sv - per-partition minimum-SAD and motion-vector selector
//
// Tracks, for each of NUM_PART partitions independently, the smallest SAD seen
// across a stream of candidate beats and the motion vector that produced it.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   start       one-cycle pulse: clear results and begin a new search
//   valid_in    candidate beat present
//   last_in     current valid beat is the final candidate
//   mvx_in      signed x displacement of the current candidate
//   mvy_in      signed y displacement of the current candidate
//   sad_in      partition SADs of the current candidate
//   busy        high while searching
//   done        one-cycle pulse when results are final
//   min_sad     best SAD per partition
//   best_mvx    x component of the MV that produced min_sad
//   best_mvy    y component of the MV that produced min_sad
//   cand_count  candidates accepted in the current or last search (saturating)
//
// Partition index order: 0-15 4x4 row-major, 16-23 4x8, 24-31 8x4 (column
// order), 32-35 8x8, 36-37 16x8, 38-39 8x16, 40 16x16. The datapath treats
// every index identically; the order only matters to producer and consumer.
module sad_min_select #(
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 6,
  parameter int NUM_PART  = 41,
  parameter int CNT_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        valid_in,
  input  logic                        last_in,
  input  logic signed [MV_WIDTH-1:0]  mvx_in,
  input  logic signed [MV_WIDTH-1:0]  mvy_in,
  input  logic        [SAD_WIDTH-1:0] sad_in   [0:NUM_PART-1],
  output logic                        busy,
  output logic                        done,
  output logic        [SAD_WIDTH-1:0] min_sad  [0:NUM_PART-1],
  output logic signed [MV_WIDTH-1:0]  best_mvx [0:NUM_PART-1],
  output logic signed [MV_WIDTH-1:0]  best_mvy [0:NUM_PART-1],
  output logic        [CNT_WIDTH-1:0] cand_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t state;

  // Decoded straight from the state register so busy has no input path.
  assign busy = (state == S_SEARCH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      cand_count <= '0;
      for (int p = 0; p < NUM_PART; p++) begin
        min_sad[p]  <= '1;
        best_mvx[p] <= '0;
        best_mvy[p] <= '0;
      end
    end else if (start) begin
      // start wins over a coincident beat: that beat is dropped.
      state      <= S_SEARCH;
      done       <= 1'b0;
      cand_count <= '0;
      for (int p = 0; p < NUM_PART; p++) begin
        min_sad[p]  <= '1;
        best_mvx[p] <= '0;
        best_mvy[p] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
        end
        S_SEARCH: begin
          if (valid_in) begin
            // Strict compare keeps the earliest candidate on a tie.
            for (int p = 0; p < NUM_PART; p++) begin
              if (sad_in[p] < min_sad[p]) begin
                min_sad[p]  <= sad_in[p];
                best_mvx[p] <= mvx_in;
                best_mvy[p] <= mvy_in;
              end
            end
            if (cand_count != {CNT_WIDTH{1'b1}}) begin
              cand_count <= cand_count + 1'b1;
            end
            if (last_in) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sad_min_select.md
SAD_MIN_SELECT -- requirements
Module: sad_min_select

Interface
REQ-001 SHALL have parameter SAD_WIDTH, default 16, bit width of each partition SAD.
REQ-002 SHALL have parameter MV_WIDTH, default 6, signed two's-complement width of each motion-vector component.
REQ-003 SHALL have parameter NUM_PART, default 41, number of partition SADs per candidate.
REQ-004 SHALL have parameter CNT_WIDTH, default 10, width of the candidate counter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a new search.
REQ-008 SHALL have port valid_in  input  1  a candidate beat is present this cycle.
REQ-009 SHALL have port last_in  input  1  the current valid beat is the final candidate; qualified by valid_in.
REQ-010 SHALL have port mvx_in, mvy_in  input  MV_WIDTH each  signed displacement of the current candidate.
REQ-011 SHALL have port sad_in  input  [0:NUM_PART-1] x SAD_WIDTH  partition SADs for the current candidate.
REQ-012 SHALL have port busy  output  1  high while in SEARCH.
REQ-013 SHALL have port done  output  1  one-cycle pulse when results are final.
REQ-014 SHALL have port min_sad  output  [0:NUM_PART-1] x SAD_WIDTH  best SAD per partition.
REQ-015 SHALL have port best_mvx, best_mvy  output  [0:NUM_PART-1] x MV_WIDTH  MV that produced min_sad.
REQ-016 SHALL have port cand_count  output  CNT_WIDTH  number of candidates accepted in the current or last search.

Function
REQ-017 SHALL index partitions in this fixed order: 0-15 4x4 (row-major 00..33), 16-23 4x8 (00..03, 10..13), 24-31 8x4 (00,10,20,30,01,11,21,31), 32-35 8x8 (00,10,01,11), 36-37 16x8 (0,1), 38-39 8x16 (0,1), 40 16x16.
REQ-018 SHALL implement FSM states IDLE, SEARCH, DONE; reset state IDLE.
REQ-019 SHALL transition IDLE->SEARCH on start; SEARCH->DONE on valid_in&last_in; DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL, on start in any state, reset cand_count to 0, set min_sad to all-ones, set best MVs to 0, and enter SEARCH on the next cycle; start has priority over valid_in in the same cycle (that beat is dropped).
REQ-021 SHALL accept a beat only when state is SEARCH and valid_in=1 and start=0; beats in IDLE or DONE are ignored with no state change.
REQ-022 SHALL, per partition p, on an accepted beat with sad_in[p] < min_sad[p] (unsigned, strict), update min_sad[p], best_mvx[p], best_mvy[p] on the next rising edge; on a tie the earlier candidate is kept.
REQ-023 SHALL treat all 41 partitions independently within a single cycle (one-cycle throughput, back-to-back beats allowed).
REQ-024 SHALL increment cand_count by 1 per accepted beat, saturating at 2^CNT_WIDTH-1.
REQ-025 SHALL assert done for exactly one cycle, the cycle after the accepted last beat; min_sad/best MVs including that beat are valid in that cycle.
REQ-026 SHALL hold min_sad, best MVs and cand_count stable after done until the next start.
REQ-027 SHALL assert busy combinationally from state==SEARCH (registered state, no input path).
REQ-028 SHALL report min_sad=all-ones and best MVs=0 for any partition when a search ends with no accepted beat below all-ones.

Reset
REQ-029 SHALL, when rst=0 at a rising edge, set state IDLE, busy=0, done=0, cand_count=0, all min_sad=all-ones, all best MVs=0, overriding start and valid_in.
REQ-030 SHALL abandon a search in progress on reset with no done pulse.

Verification
REQ-031 Three beats (mv (1,1),(−2,0),(3,−3)) with sad_in all = 50, 20, 30, last on third -> done one cycle later; all min_sad=20, best MV=(−2,0), cand_count=3.
REQ-032 Two beats: beat A p0=10, p40=90; beat B p0=10, p40=80 -> p0 keeps A's MV (tie), p40 takes B's MV with min 80.
REQ-033 start and valid_in asserted together in SEARCH with sad=1 -> beat dropped, min_sad all-ones, cand_count=0, busy=1 next cycle.
REQ-034 valid_in with sad=0 while IDLE and during DONE -> no change to outputs, cand_count unchanged, no done.
REQ-035 rst=0 mid-search after 5 beats -> next cycle busy=0, cand_count=0, min_sad all-ones, done never pulses.
REQ-036 1100 back-to-back beats with CNT_WIDTH=10 -> cand_count saturates at 1023; minima still track all beats.
